camellia_f_func: RTL and testbench



---
 rtl/camellia_f_func.sv | 179 +++++++++++++++++
 tb/tb_camellia_f_func.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/camellia_f_func.sv
// Camellia F-function for the 128-bit datapath, with its four dual-port S-box ROMs.
package camellia_sbox_pkg;

    localparam int SBOX1_TBL [256] = '{
        112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
         35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
        134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
        166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
        139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
        223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
         20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
        254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
        170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
         16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
        135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
         82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
        233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
        120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
        114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
         64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
    };

    function automatic logic [7:0] s1(input logic [7:0] x);
        return SBOX1_TBL[x][7:0];
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] rotr1(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

endpackage

// SBOX_1 dual-port ROM.
// Latency: 1 cycle, address sampled on clk, data valid next cycle.
// Backpressure: none; free-running, no reset.
module sbox_1 (
    input  logic       clk,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b
);
    always_ff @(posedge clk) begin
        dout_a <= camellia_sbox_pkg::s1(addr_a);
        dout_b <= camellia_sbox_pkg::s1(addr_b);
    end
endmodule

// SBOX_2 dual-port ROM: SBOX_1 output rotated left by one.
// Latency: 1 cycle, address sampled on clk, data valid next cycle.
// Backpressure: none; free-running, no reset.
module sbox_2 (
    input  logic       clk,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b
);
    always_ff @(posedge clk) begin
        dout_a <= camellia_sbox_pkg::rotl1(camellia_sbox_pkg::s1(addr_a));
        dout_b <= camellia_sbox_pkg::rotl1(camellia_sbox_pkg::s1(addr_b));
    end
endmodule

// SBOX_3 dual-port ROM: SBOX_1 output rotated right by one.
// Latency: 1 cycle, address sampled on clk, data valid next cycle.
// Backpressure: none; free-running, no reset.
module sbox_3 (
    input  logic       clk,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b
);
    always_ff @(posedge clk) begin
        dout_a <= camellia_sbox_pkg::rotr1(camellia_sbox_pkg::s1(addr_a));
        dout_b <= camellia_sbox_pkg::rotr1(camellia_sbox_pkg::s1(addr_b));
    end
endmodule

// SBOX_4 dual-port ROM: SBOX_1 indexed by the address rotated left by one.
// Latency: 1 cycle, address sampled on clk, data valid next cycle.
// Backpressure: none; free-running, no reset.
module sbox_4 (
    input  logic       clk,
    input  logic [7:0] addr_a,
    input  logic [7:0] addr_b,
    output logic [7:0] dout_a,
    output logic [7:0] dout_b
);
    always_ff @(posedge clk) begin
        dout_a <= camellia_sbox_pkg::s1(camellia_sbox_pkg::rotl1(addr_a));
        dout_b <= camellia_sbox_pkg::s1(camellia_sbox_pkg::rotl1(addr_b));
    end
endmodule

// Camellia F-function: S-box layer on (f_in ^ k_in) followed by the P-function.
// Latency: start at edge N gives done/f_out in cycle N+3; one op per 3 cycles.
// Backpressure: none; start is ignored while busy, f_out held until next done.
module camellia_f_func (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] f_in,
    input  logic [63:0] k_in,
    output logic        busy,
    output logic        done,
    output logic [63:0] f_out
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CALC = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] x_reg;
    logic [7:0]  y1, y2, y3, y4, y5, y6, y7, y8;
    logic [7:0]  z1, z2, z3, z4, z5, z6, z7, z8;
    logic [63:0] z;

    // Addresses track x_reg continuously; only the READ-edge sample is consumed.
    sbox_1 u_sbox_1 (.clk(clk), .addr_a(x_reg[63:56]), .addr_b(x_reg[7:0]),
                     .dout_a(y1), .dout_b(y8));
    sbox_2 u_sbox_2 (.clk(clk), .addr_a(x_reg[55:48]), .addr_b(x_reg[31:24]),
                     .dout_a(y2), .dout_b(y5));
    sbox_3 u_sbox_3 (.clk(clk), .addr_a(x_reg[47:40]), .addr_b(x_reg[23:16]),
                     .dout_a(y3), .dout_b(y6));
    sbox_4 u_sbox_4 (.clk(clk), .addr_a(x_reg[39:32]), .addr_b(x_reg[15:8]),
                     .dout_a(y4), .dout_b(y7));

    always_comb begin
        z1 = y1 ^ y3 ^ y4 ^ y6 ^ y7 ^ y8;
        z2 = y1 ^ y2 ^ y4 ^ y5 ^ y7 ^ y8;
        z3 = y1 ^ y2 ^ y3 ^ y5 ^ y6 ^ y8;
        z4 = y2 ^ y3 ^ y4 ^ y5 ^ y6 ^ y7;
        z5 = y1 ^ y2 ^ y6 ^ y7 ^ y8;
        z6 = y2 ^ y3 ^ y5 ^ y7 ^ y8;
        z7 = y3 ^ y4 ^ y5 ^ y6 ^ y8;
        z8 = y1 ^ y4 ^ y5 ^ y6 ^ y7;
        z  = {z1, z2, z3, z4, z5, z6, z7, z8};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = READ;
            READ:    state_d = CALC;
            CALC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_reg   <= 64'h0;
            f_out   <= 64'h0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == CALC);
            if (state_q == IDLE && start) begin
                x_reg <= f_in ^ k_in;
            end
            if (state_q == CALC) begin
                f_out <= z;
            end
        end
    end

endmodule

// File: tb/tb_camellia_f_func.sv
// Directed and randomized checks of camellia_f_func against an independent F model.
module tb_camellia_f_func;

    localparam int SBOX1_REF [256] = '{
        112, 130,  44, 236, 179,  39, 192, 229, 228, 133,  87,  53, 234,  12, 174,  65,
         35, 239, 107, 147,  69,  25, 165,  33, 237,  14,  79,  78,  29, 101, 146, 189,
        134, 184, 175, 143, 124, 235,  31, 206,  62,  48, 220,  95,  94, 197,  11,  26,
        166, 225,  57, 202, 213,  71,  93,  61, 217,   1,  90, 214,  81,  86, 108,  77,
        139,  13, 154, 102, 251, 204, 176,  45, 116,  18,  43,  32, 240, 177, 132, 153,
        223,  76, 203, 194,  52, 126, 118,   5, 109, 183, 169,  49, 209,  23,   4, 215,
         20,  88,  58,  97, 222,  27,  17,  28,  50,  15, 156,  22,  83,  24, 242,  34,
        254,  68, 207, 178, 195, 181, 122, 145,  36,   8, 232, 168,  96, 252, 105,  80,
        170, 208, 160, 125, 161, 137,  98, 151,  84,  91,  30, 149, 224, 255, 100, 210,
         16, 196,   0,  72, 163, 247, 117, 219, 138,   3, 230, 218,   9,  63, 221, 148,
        135,  92, 131,   2, 205,  74, 144,  51, 115, 103, 246, 243, 157, 127, 191, 226,
         82, 155, 216,  38, 200,  55, 198,  59, 129, 150, 111,  75,  19, 190,  99,  46,
        233, 121, 167, 140, 159, 110, 188, 142,  41, 245, 249, 182,  47, 253, 180,  89,
        120, 152,   6, 106, 231,  70, 113, 186, 212,  37, 171,  66, 136, 162, 141, 250,
        114,   7, 185,  85, 248, 238, 172,  10,  54,  73,  42, 104,  60,  56, 241, 164,
         64,  40, 211, 123, 187, 201,  67, 193,  21, 227, 173, 244, 119, 199, 128, 158
    };

    // Row i lists which of y1..y8 (bit 7 = y1) are XORed into z(i+1).
    localparam logic [7:0] P_MASK [8] = '{
        8'b10110111, 8'b11011011, 8'b11101101, 8'b01111110,
        8'b11000111, 8'b01101011, 8'b00111101, 8'b10011110
    };

    localparam logic [63:0] ZERO_F = 64'h00000000A838E0A8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] f_in;
    logic [63:0] k_in;
    logic        busy;
    logic        done;
    logic [63:0] f_out;

    int n_vec = 0;
    int n_err = 0;

    camellia_f_func dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .f_in  (f_in),
        .k_in  (k_in),
        .busy  (busy),
        .done  (done),
        .f_out (f_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input int which, input logic [7:0] t);
        logic [7:0] v;
        case (which)
            1: v = SBOX1_REF[t][7:0];
            2: begin v = SBOX1_REF[t][7:0]; v = {v[6:0], v[7]}; end
            3: begin v = SBOX1_REF[t][7:0]; v = {v[0], v[7:1]}; end
            default: v = SBOX1_REF[{t[6:0], t[7]}][7:0];
        endcase
        return v;
    endfunction

    function automatic logic [63:0] f_ref(input logic [63:0] f, input logic [63:0] k);
        logic [63:0] x;
        logic [7:0]  t [8];
        logic [7:0]  y [8];
        logic [7:0]  zb;
        logic [63:0] r;
        // S-box selection per byte position t1..t8
        int          sel [8] = '{1, 2, 3, 4, 2, 3, 4, 1};
        x = f ^ k;
        for (int i = 0; i < 8; i++) begin
            t[i] = x[63 - 8*i -: 8];
            y[i] = sb(sel[i], t[i]);
        end
        r = 64'h0;
        for (int i = 0; i < 8; i++) begin
            zb = 8'h0;
            for (int j = 0; j < 8; j++) begin
                if (P_MASK[i][7 - j]) zb = zb ^ y[j];
            end
            r[63 - 8*i -: 8] = zb;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full operation with start accepted at edge N; checks cycles N+1..N+3.
    task automatic run_op(input string tag, input logic [63:0] f, input logic [63:0] k,
                          input logic [63:0] exp);
        start = 1'b1;
        f_in  = f;
        k_in  = k;
        step();
        start = 1'b0;
        f_in  = ~f;
        k_in  = 64'h0;
        chk({tag, "_busy1"}, 64'(busy), 64'd1);
        chk({tag, "_done1"}, 64'(done), 64'd0);
        step();
        chk({tag, "_busy2"}, 64'(busy), 64'd1);
        step();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_fout"}, f_out, exp);
    endtask

    initial begin
        logic [63:0] fa, ka, fb, kb;
        rst   = 1'b1;
        start = 1'b1;
        f_in  = 64'h0;
        k_in  = 64'h0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_done", 64'(done), 64'd0);
            chk("rst_fout", f_out, 64'h0);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_done", 64'(done), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
        end

        run_op("zero", 64'h0, 64'h0, ZERO_F);
        step();
        chk("zero_done_drop", 64'(done), 64'd0);
        chk("zero_fout_hold", f_out, ZERO_F);

        run_op("keycancel", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, ZERO_F);
        step();

        // Second start while busy must be ignored.
        start = 1'b1;
        f_in  = 64'h0;
        k_in  = 64'h0;
        step();
        f_in  = 64'hFFFFFFFFFFFFFFFF;
        chk("rej_busy1", 64'(busy), 64'd1);
        step();
        start = 1'b0;
        chk("rej_busy2", 64'(busy), 64'd1);
        step();
        chk("rej_done", 64'(done), 64'd1);
        chk("rej_fout", f_out, ZERO_F);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rej_no_second_done", 64'(done), 64'd0);
            chk("rej_idle", 64'(busy), 64'd0);
        end

        // Back-to-back: restart in the done cycle.
        fa = 64'h0011223344556677;
        ka = 64'h8899AABBCCDDEEFF;
        fb = 64'hFEDCBA9876543210;
        kb = 64'h0F1E2D3C4B5A6978;
        run_op("b2b_first", fa, ka, f_ref(fa, ka));
        start = 1'b1;
        f_in  = fb;
        k_in  = kb;
        step();
        start = 1'b0;
        chk("b2b_n4_done", 64'(done), 64'd0);
        chk("b2b_n4_hold", f_out, f_ref(fa, ka));
        step();
        chk("b2b_n5_hold", f_out, f_ref(fa, ka));
        step();
        chk("b2b_second_done", 64'(done), 64'd1);
        chk("b2b_second_fout", f_out, f_ref(fb, kb));

        // Abort: reset lands on the edge that would have completed the op.
        start = 1'b1;
        f_in  = 64'h1111111111111111;
        k_in  = 64'h2222222222222222;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_fout", f_out, 64'h0);
        step();
        chk("abort_no_done", 64'(done), 64'd0);
        chk("abort_fout_n3", f_out, 64'h0);
        run_op("after_abort", 64'h1111111111111111, 64'h2222222222222222,
               f_ref(64'h1111111111111111, 64'h2222222222222222));

        for (int i = 0; i < 1000; i++) begin
            fa = {$urandom, $urandom};
            ka = {$urandom, $urandom};
            run_op("rand", fa, ka, f_ref(fa, ka));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
